// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // Sample-tick divider, integer floor of clock/(baud*oversample).
   function automatic int unsigned baud_div(input int unsigned clock_freq,
                                            input int unsigned baud_rate,
                                            input int unsigned oversample);
      return clock_freq / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO; push is accepted when full only if a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// Oversampling 8N1 UART receiver with majority-vote sampling, feeding a small FWFT byte FIFO.
module uart_rx_frontend
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000_000,
   parameter int unsigned BAUD_RATE  = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          rx_in,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          rx_busy,
   output logic                          frame_error,
   output logic                          overrun_error,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned DIV      = baud_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned OS_W     = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W    = $clog2(DATA_BITS);
   localparam int unsigned VOTE_END = OVERSAMPLE / 2 + 1;

   logic                 rx_meta_q, rx_sync_q;
   logic                 rxs;
   rx_state_t            state_q, state_d;
   logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
   logic [OS_W-1:0]      samp_cnt_q, samp_cnt_d;
   logic [1:0]           hist_q, hist_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 busy_q, busy_d;
   logic                 frame_error_q, frame_error_d;
   logic                 overrun_q, overrun_d;
   logic                 tick_c, vote_c, vote_end_c, push_c, pop_c;
   logic                 fifo_full, fifo_empty;

   // Two-flop synchronizer, preset to the idle-high line level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_in;
         rx_sync_q <= rx_meta_q;
      end
   end

   assign rxs   = rx_sync_q;
   assign pop_c = rx_ready && !fifo_empty;

   always_comb begin
      tick_c        = (div_cnt_q == DIV_W'(DIV - 1));
      vote_c        = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
      vote_end_c    = tick_c && (samp_cnt_q == OS_W'(VOTE_END));
      state_d       = state_q;
      div_cnt_d     = tick_c ? '0 : div_cnt_q + DIV_W'(1);
      samp_cnt_d    = samp_cnt_q;
      hist_d        = hist_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      push_c        = 1'b0;
      frame_error_d = 1'b0;

      if (tick_c) begin
         hist_d     = {hist_q[0], rxs};
         samp_cnt_d = (samp_cnt_q == OS_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + OS_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            // Realign tick phase to the start edge.
            if (!rxs) begin
               state_d    = START;
               div_cnt_d  = '0;
               samp_cnt_d = '0;
               bit_cnt_d  = '0;
            end
         end
         START: begin
            if (vote_end_c) begin
               state_d = vote_c ? IDLE : DATA;
            end
         end
         DATA: begin
            if (vote_end_c) begin
               shift_d   = {vote_c, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (vote_end_c) begin
               if (vote_c) begin
                  push_c  = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            // Two consecutive high samples mean the line is back to idle.
            if (tick_c && rxs && hist_q[0]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d    = (state_d != IDLE);
      overrun_d = push_c && fifo_full && !pop_c;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         div_cnt_q     <= '0;
         samp_cnt_q    <= '0;
         hist_q        <= 2'b11;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         busy_q        <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_cnt_q     <= div_cnt_d;
         samp_cnt_q    <= samp_cnt_d;
         hist_q        <= hist_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         busy_q        <= busy_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .push    (push_c),
      .wr_data (shift_d),
      .pop     (pop_c),
      .rd_data (rx_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign rx_valid      = !fifo_empty;
   assign rx_busy       = busy_q;
   assign frame_error   = frame_error_q;
   assign overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at DIV=2 (32 clocks per bit).
module tb_uart_rx_frontend;

   localparam int unsigned FIFO_DEPTH = 8;
   localparam int          BIT_CLKS   = 32;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rx_in = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_error;
   logic       overrun_error;
   logic [3:0] fifo_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int start_cyc = 0;
   int pop_cyc = 0;
   int pop_total = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   uart_rx_frontend #(
      .CLOCK_FREQ (3_200_000),
      .BAUD_RATE  (100_000),
      .OVERSAMPLE (16),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rx_in         (rx_in),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_busy       (rx_busy),
      .frame_error   (frame_error),
      .overrun_error (overrun_error),
      .fifo_count    (fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops the expected byte whenever the DUT hands one over.
   always @(negedge clk) begin
      if (reset_n) begin
         if (frame_error) fe_cnt++;
         if (overrun_error) ov_cnt++;
         if (rx_valid && rx_ready) begin
            total++;
            pop_total++;
            pop_cyc = cyc;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL pop_unexpected got=%02h required=none", rx_data);
            end else begin
               mon_exp = exp_q.pop_front();
               if (rx_data !== mon_exp) begin
                  bad++;
                  $display("FAIL pop_data got=%02h required=%02h", rx_data, mon_exp);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bclk);
      logic [9:0] fr;
      fr = {stop_b, d, 1'b0};
      @(posedge clk);
      #1;
      start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         rx_in = fr[i];
         repeat (bclk) @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, int'(rx_valid), 0);
      check({tag, "_busy"}, int'(rx_busy), 0);
      check({tag, "_count"}, int'(fifo_count), 0);
      check({tag, "_data"}, int'(rx_data), 0);
      check({tag, "_ferr"}, int'(frame_error), 0);
      check({tag, "_oerr"}, int'(overrun_error), 0);
   endtask

   initial begin
      idle(3);
      check_all_zero("reset");
      reset_n = 1'b1;
      idle(5);

      // Clean 0x55, latency from start edge to rx_valid.
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, BIT_CLKS);
      idle(40);
      check("t1_latency", pop_cyc - start_cyc, 311);
      check("t1_count", int'(fifo_count), 0);
      check("t1_ferr", fe_cnt, 0);
      check("t1_pops", pop_total, 1);

      // Short low glitch: busy briefly, nothing received.
      rx_in = 1'b0;
      idle(8);
      rx_in = 1'b1;
      check("t2_busy_hi", int'(rx_busy), 1);
      idle(60);
      check("t2_busy_lo", int'(rx_busy), 0);
      check("t2_pops", pop_total, 1);
      check("t2_ferr", fe_cnt, 0);
      check("t2_oerr", ov_cnt, 0);

      // Bad stop bit then line held low, followed by a good frame.
      send_frame(8'hA3, 1'b0, BIT_CLKS);
      idle(2 * BIT_CLKS);
      rx_in = 1'b1;
      idle(80);
      check("t3_ferr", fe_cnt, 1);
      check("t3_pops_err", pop_total, 1);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, BIT_CLKS);
      idle(40);
      check("t3_pops", pop_total, 2);

      // Fill the FIFO with the consumer stalled, overrun on the ninth byte.
      rx_ready = 1'b0;
      for (int b = 0; b < 9; b++) begin
         if (b < 8) exp_q.push_back(8'(b));
         send_frame(8'(b), 1'b1, BIT_CLKS);
         idle(8);
      end
      check("t4_count_full", int'(fifo_count), 8);
      check("t4_oerr", ov_cnt, 1);
      check("t4_valid", int'(rx_valid), 1);
      check("t4_head", int'(rx_data), 0);
      rx_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (fifo_count == 0) break;
         idle(1);
      end
      idle(2);
      check("t4_count_empty", int'(fifo_count), 0);
      check("t4_pops", pop_total, 10);
      check("t4_ferr", fe_cnt, 1);

      // Reset mid data bit 4 of 0x96.
      fork
         send_frame(8'h96, 1'b1, BIT_CLKS);
         begin
            repeat (172) @(posedge clk);
            #2;
            check("t5_busy_pre", int'(rx_busy), 1);
            reset_n = 1'b0;
            #1;
            check_all_zero("t5_rst");
         end
      join
      rx_in = 1'b1;
      idle(5);
      reset_n = 1'b1;
      idle(20);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1, BIT_CLKS);
      idle(40);
      check("t5_pops", pop_total, 11);

      // Baud mismatch of +/-3%.
      exp_q.push_back(8'hC9);
      send_frame(8'hC9, 1'b1, 33);
      idle(40);
      check("t6_pops_slow", pop_total, 12);
      exp_q.push_back(8'hC9);
      send_frame(8'hC9, 1'b1, 31);
      idle(40);
      check("t6_pops_fast", pop_total, 13);
      check("t6_ferr", fe_cnt, 1);
      check("t6_oerr", ov_cnt, 1);
      check("exp_left", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
